// File: rtl/line_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : line_window_buffer
// Purpose  : K-row sliding-window line buffer. Fetches whole rows from the
//            frame row memory (req/valid), keeps the last K rows in registers
//            and presents a vertically padded window centred on each image row
//            with valid/ready flow control.
// Options  : LWB_EDGE_REPLICATE_EN - replicate edge rows instead of zero pad.
// Revision : 1.0 - initial release
// ============================================================================
module line_window_buffer #(
    parameter int PIX_W  = 1,
    parameter int IMG_W  = 1280,
    parameter int IMG_H  = 720,
    parameter int K      = 3,
    parameter int ADDR_W = 10
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    output logic                       rd_req,
    output logic [ADDR_W-1:0]          rd_addr,
    input  logic                       rd_valid,
    input  logic [IMG_W*PIX_W-1:0]     rd_data,
    output logic [K*IMG_W*PIX_W-1:0]   win_data,
    output logic [ADDR_W-1:0]          win_row,
    output logic                       win_valid,
    input  logic                       win_ready,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int c_rw = IMG_W * PIX_W;
    localparam int c_h  = (K - 1) / 2;

    localparam logic [ADDR_W:0]   c_h_ext      = (ADDR_W + 1)'(c_h);
    localparam logic [ADDR_W:0]   c_img_h_ext  = (ADDR_W + 1)'(IMG_H);
    localparam logic [ADDR_W-1:0] c_last_row   = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] c_prime_last = ADDR_W'(c_h - 1);
    localparam logic [ADDR_W-1:0] c_one        = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRIME   = 3'd1,
        S_FETCH   = 3'd2,
        S_PRESENT = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   r_q, r_d;
    logic [ADDR_W-1:0]   f_q, f_d;
    logic                rd_req_q, rd_req_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                win_valid_q, win_valid_d;
    logic                busy_q, busy_d;
    logic                frame_done_q, frame_done_d;
    logic [c_rw-1:0]     line_q [K];
    logic [c_rw-1:0]     line_d [K];

    logic                clear_lines;
    logic                fill_all;
    logic                shift_en;
    logic [c_rw-1:0]     shift_row;
    logic [c_rw-1:0]     w_pad_row;
    logic [ADDR_W:0]     w_next_fetch;
    logic                w_next_need;

`ifdef LWB_EDGE_REPLICATE_EN
    assign w_pad_row = line_q[K-1];
`else
    assign w_pad_row = '0;
`endif

    // Row that the following window needs from memory once r advances.
    assign w_next_fetch = {1'b0, r_q} + (ADDR_W + 1)'(1) + c_h_ext;
    assign w_next_need  = (w_next_fetch < c_img_h_ext);

    // Frame sequencing and read handshake next-state logic.
    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        f_d          = f_q;
        rd_req_d     = rd_req_q;
        rd_addr_d    = rd_addr_q;
        win_valid_d  = win_valid_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        clear_lines  = 1'b0;
        fill_all     = 1'b0;
        shift_en     = 1'b0;
        shift_row    = rd_data;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_PRIME;
                    clear_lines = 1'b1;
                    r_d         = '0;
                    f_d         = '0;
                    rd_req_d    = 1'b1;
                    rd_addr_d   = '0;
                    busy_d      = 1'b1;
                end
            end
            S_PRIME: begin
                if (rd_valid) begin
                    f_d = f_q + c_one;
`ifdef LWB_EDGE_REPLICATE_EN
                    // Row 0 seeds every line so the top edge repeats it.
                    if (f_q == '0) fill_all = 1'b1;
                    else           shift_en = 1'b1;
`else
                    shift_en = 1'b1;
`endif
                    if (f_q == c_prime_last) begin
                        // Issue the first centre fetch back-to-back.
                        state_d   = S_FETCH;
                        rd_req_d  = (c_h_ext < c_img_h_ext);
                        rd_addr_d = ADDR_W'(c_h);
                    end else begin
                        rd_addr_d = f_q + c_one;
                    end
                end
            end
            S_FETCH: begin
                if (rd_req_q) begin
                    if (rd_valid) begin
                        shift_en    = 1'b1;
                        rd_req_d    = 1'b0;
                        win_valid_d = 1'b1;
                        state_d     = S_PRESENT;
                    end
                end else begin
                    // Below the last image row: one-cycle padding shift.
                    shift_en    = 1'b1;
                    shift_row   = w_pad_row;
                    win_valid_d = 1'b1;
                    state_d     = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (win_ready) begin
                    win_valid_d = 1'b0;
                    if (r_q == c_last_row) begin
                        state_d      = S_DONE;
                        frame_done_d = 1'b1;
                    end else begin
                        r_d      = r_q + c_one;
                        state_d  = S_FETCH;
                        rd_req_d = w_next_need;
                        if (w_next_need) rd_addr_d = w_next_fetch[ADDR_W-1:0];
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Line storage update: clear, replicate-fill or shift up by one row.
    always_comb begin
        for (int i = 0; i < K; i++) line_d[i] = line_q[i];
        if (clear_lines) begin
            for (int i = 0; i < K; i++) line_d[i] = '0;
        end else if (fill_all) begin
            for (int i = 0; i < K; i++) line_d[i] = rd_data;
        end else if (shift_en) begin
            for (int i = 0; i < K - 1; i++) line_d[i] = line_q[i+1];
            line_d[K-1] = shift_row;
        end
    end

    // State and output registers; reset drops every output at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            r_q          <= '0;
            f_q          <= '0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            win_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            for (int i = 0; i < K; i++) line_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            f_q          <= f_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            win_valid_q  <= win_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            line_q       <= line_d;
        end
    end

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_win
            assign win_data[gi*c_rw +: c_rw] = line_q[gi];
        end
    endgenerate

    assign rd_req     = rd_req_q;
    assign rd_addr    = rd_addr_q;
    assign win_row    = r_q;
    assign win_valid  = win_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_line_window_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_window_buffer
// Purpose  : Scoreboard bench for line_window_buffer with K=3 and K=5
//            instances sharing one row-memory model (8x8-bit rows, 4 rows,
//            row n filled with byte n+1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_window_buffer;

    localparam int PIX_W  = 8;
    localparam int IMG_W  = 8;
    localparam int IMG_H  = 4;
    localparam int ADDR_W = 4;
    localparam int RW     = PIX_W * IMG_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start3 = 1'b0, start5 = 1'b0;
    logic rdy = 1'b1;
    logic rd_valid = 1'b0;
    logic [RW-1:0] rd_data = '0;
    logic sel = 1'b0;

    logic               rd_req3, rd_req5, win_valid3, win_valid5;
    logic               busy3, busy5, fd3, fd5;
    logic [ADDR_W-1:0]  rd_addr3, rd_addr5, win_row3, win_row5;
    logic [3*RW-1:0]    win_data3;
    logic [5*RW-1:0]    win_data5;

    logic               s_req, s_valid, s_busy, s_fd;
    logic [ADDR_W-1:0]  s_addr, s_row;
    logic [5*RW-1:0]    s_data;

    always #5 clk = ~clk;

    line_window_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(3), .ADDR_W(ADDR_W)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .rd_req(rd_req3), .rd_addr(rd_addr3),
        .rd_valid(rd_valid), .rd_data(rd_data), .win_data(win_data3), .win_row(win_row3),
        .win_valid(win_valid3), .win_ready(rdy), .busy(busy3), .frame_done(fd3));

    line_window_buffer #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .K(5), .ADDR_W(ADDR_W)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .start(start5), .rd_req(rd_req5), .rd_addr(rd_addr5),
        .rd_valid(rd_valid), .rd_data(rd_data), .win_data(win_data5), .win_row(win_row5),
        .win_valid(win_valid5), .win_ready(rdy), .busy(busy5), .frame_done(fd5));

    assign s_req   = sel ? rd_req5    : rd_req3;
    assign s_addr  = sel ? rd_addr5   : rd_addr3;
    assign s_valid = sel ? win_valid5 : win_valid3;
    assign s_row   = sel ? win_row5   : win_row3;
    assign s_busy  = sel ? busy5      : busy3;
    assign s_fd    = sel ? fd5        : fd3;
    assign s_data  = sel ? win_data5  : {{(2*RW){1'b0}}, win_data3};

    // Hand-computed window line bytes, slice 0 (top) first, one entry per row.
`ifdef LWB_EDGE_REPLICATE_EN
    logic [7:0] t3 [4][3] = '{'{8'd1,8'd1,8'd2}, '{8'd1,8'd2,8'd3}, '{8'd2,8'd3,8'd4}, '{8'd3,8'd4,8'd4}};
    logic [7:0] t5 [4][5] = '{'{8'd1,8'd1,8'd1,8'd2,8'd3}, '{8'd1,8'd1,8'd2,8'd3,8'd4},
                              '{8'd1,8'd2,8'd3,8'd4,8'd4}, '{8'd2,8'd3,8'd4,8'd4,8'd4}};
`else
    logic [7:0] t3 [4][3] = '{'{8'd0,8'd1,8'd2}, '{8'd1,8'd2,8'd3}, '{8'd2,8'd3,8'd4}, '{8'd3,8'd4,8'd0}};
    logic [7:0] t5 [4][5] = '{'{8'd0,8'd0,8'd1,8'd2,8'd3}, '{8'd0,8'd1,8'd2,8'd3,8'd4},
                              '{8'd1,8'd2,8'd3,8'd4,8'd0}, '{8'd2,8'd3,8'd4,8'd0,8'd0}};
`endif

    typedef struct {
        logic [ADDR_W-1:0] row;
        logic [5*RW-1:0]   data;
    } exp_t;

    exp_t              exp_q [$];
    logic [ADDR_W-1:0] addr_q [$];
    int errors = 0;
    int checks = 0;
    int fd_cnt = 0;
    int lat = 1;
    bit rand_gap = 1'b0;
    bit mem_busy = 1'b0;

    task automatic chk(input string nm, input logic [5*RW-1:0] act, input logic [5*RW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [5*RW-1:0] exp_win(input bit k5, input int r);
        logic [5*RW-1:0] v;
        v = '0;
        if (k5) for (int i = 0; i < 5; i++) v[i*RW +: RW] = {8{t5[r][i]}};
        else    for (int i = 0; i < 3; i++) v[i*RW +: RW] = {8{t3[r][i]}};
        return v;
    endfunction

    // Row memory: answers each request `lat` (+ optional gap) cycles after it is seen.
    initial begin
        logic [ADDR_W-1:0] a;
        int n;
        @(negedge clk);
        forever begin
            if (s_req && rst_n) begin
                a = s_addr;
                mem_busy = 1'b1;
                addr_q.push_back(a);
                n = lat + (rand_gap ? int'($urandom_range(0, 3)) : 0);
                repeat (n) @(negedge clk);
                rd_valid = 1'b1;
                rd_data  = {8{8'(a) + 8'd1}};
                @(negedge clk);
                rd_valid = 1'b0;
                mem_busy = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted window, checks handshake rules.
    initial begin
        logic prev_req, prev_vld, fd_prev;
        logic [ADDR_W-1:0] prev_addr;
        exp_t e;
        prev_req = 1'b0; prev_vld = 1'b0; fd_prev = 1'b0; prev_addr = '0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst_n) begin
                prev_req = 1'b0;
                fd_prev  = 1'b0;
            end else begin
                if (prev_req && !prev_vld && s_req)
                    chk("rd_addr_stable", (5*RW)'(s_addr), (5*RW)'(prev_addr));
                prev_req  = s_req;
                prev_addr = s_addr;
                prev_vld  = rd_valid;
                if (s_valid && rdy) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_window: got row %0d expected none", s_row);
                    end else begin
                        e = exp_q.pop_front();
                        chk("win_row", (5*RW)'(s_row), (5*RW)'(e.row));
                        chk("win_data", s_data, e.data);
                    end
                end
                if (fd_prev) chk("busy_after_done", (5*RW)'(s_busy), (5*RW)'(0));
                if (s_fd) begin
                    fd_cnt++;
                    chk("busy_at_done", (5*RW)'(s_busy), (5*RW)'(1));
                end
                fd_prev = s_fd;
            end
        end
    end

    task automatic run_frame(input bit use5, input int l, input bit gaps, input bit stall);
        int cyc;
        exp_t e;
        logic [5*RW-1:0] hold_d;
        logic [ADDR_W-1:0] hold_r;
        sel = use5; lat = l; rand_gap = gaps;
        for (int r = 0; r < IMG_H; r++) begin
            e.row  = ADDR_W'(r);
            e.data = exp_win(use5, r);
            exp_q.push_back(e);
        end
        addr_q.delete();
        fd_cnt = 0;
        @(negedge clk);
        if (use5) start5 = 1'b1; else start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0; start5 = 1'b0;
        #1;
        chk("first_rd_req", (5*RW)'(s_req), (5*RW)'(1));
        chk("first_rd_addr", (5*RW)'(s_addr), (5*RW)'(0));
        chk("busy_after_start", (5*RW)'(s_busy), (5*RW)'(1));
        if (stall) begin
            cyc = 0;
            while (!(s_valid && s_row == 1) && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc >= 200) begin
                checks++; errors++;
                $display("FAIL stall_wait: got timeout expected window 1");
            end
            rdy = 1'b0;
            hold_d = s_data;
            hold_r = s_row;
            for (int j = 0; j < 5; j++) begin
                @(negedge clk);
                start3 = (j == 1);
                #1;
                chk("stall_data", s_data, hold_d);
                chk("stall_row", (5*RW)'(s_row), (5*RW)'(hold_r));
                chk("stall_valid", (5*RW)'(s_valid), (5*RW)'(1));
                chk("stall_no_req", (5*RW)'(s_req), (5*RW)'(0));
            end
            @(negedge clk);
            start3 = 1'b0;
            rdy = 1'b1;
        end
        cyc = 0;
        while (fd_cnt == 0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        if (fd_cnt == 0) begin
            checks++; errors++;
            $display("FAIL frame_timeout: got no frame_done expected one");
        end
        repeat (3) @(negedge clk);
        #1;
        chk("frame_done_count", (5*RW)'(fd_cnt), (5*RW)'(1));
        chk("windows_left", (5*RW)'(exp_q.size()), (5*RW)'(0));
        chk("busy_idle", (5*RW)'(s_busy), (5*RW)'(0));
        chk("rd_addr_count", (5*RW)'(addr_q.size()), (5*RW)'(IMG_H));
        for (int i = 0; i < addr_q.size() && i < IMG_H; i++)
            chk("rd_addr_seq", (5*RW)'(addr_q[i]), (5*RW)'(i));
        exp_q.delete();
    endtask

    initial begin
        int cyc;
        bit stale_seen;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_rd_req", (5*RW)'({rd_req3, rd_req5}), (5*RW)'(0));
        chk("reset_rd_addr", (5*RW)'({rd_addr3, rd_addr5}), (5*RW)'(0));
        chk("reset_win_data", (5*RW)'(win_data3) | win_data5, '0);
        chk("reset_win_row", (5*RW)'({win_row3, win_row5}), (5*RW)'(0));
        chk("reset_flags", (5*RW)'({win_valid3, win_valid5, busy3, busy5, fd3, fd5}), (5*RW)'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_frame(1'b0, 1, 1'b0, 1'b0);   // K=3, registered memory
        run_frame(1'b1, 1, 1'b0, 1'b0);   // K=5
        run_frame(1'b0, 1, 1'b0, 1'b1);   // back-pressure on window 1, start while busy
        run_frame(1'b0, 4, 1'b1, 1'b0);   // latency 4 with random gaps

        // Reset mid-frame with a read outstanding.
        sel = 1'b0; lat = 6; rand_gap = 1'b0;
        for (int r = 0; r < IMG_H; r++) exp_q.push_back('{row: ADDR_W'(r), data: exp_win(1'b0, r)});
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        cyc = 0;
        while (!(rd_req3 && rd_addr3 == 2) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 300) begin
            checks++; errors++;
            $display("FAIL reset_setup: got timeout expected rd_addr 2");
        end
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_rd_req", (5*RW)'(rd_req3), (5*RW)'(0));
        chk("midrst_rd_addr", (5*RW)'(rd_addr3), (5*RW)'(0));
        chk("midrst_win_data", (5*RW)'(win_data3), '0);
        chk("midrst_win_row", (5*RW)'(win_row3), (5*RW)'(0));
        chk("midrst_flags", (5*RW)'({win_valid3, busy3, fd3}), (5*RW)'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale_seen = 1'b0;
        cyc = 0;
        while (mem_busy && cyc < 50) begin
            @(negedge clk);
            #1;
            if (rd_req3 || win_valid3 || busy3) stale_seen = 1'b1;
            cyc++;
        end
        repeat (2) @(negedge clk);
        #1;
        if (rd_req3 || win_valid3 || busy3) stale_seen = 1'b1;
        chk("stale_rd_valid_ignored", (5*RW)'(stale_seen), (5*RW)'(0));
        run_frame(1'b0, 1, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
